// File: rtl/sat_value_uart_tx.sv
// sat_value_uart_tx
// Sends the 16-bit saturation register value off-chip as a two-byte UART 8N1
// frame, high byte first. A frame starts on a send pulse or, when AUTO_SEND is
// set, whenever the value changes. Requests that arrive while a frame is in
// flight collapse into one pending retransmission. That retransmission carries
// the newest value.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; aborts any frame in progress
//   value  - saturation register value, captured when a frame starts
//   send   - single-cycle request pulse
//   tx     - UART serial line, idles high
//   busy   - high for the full 20 bit times of a frame
//   done   - one-cycle pulse in the cycle after the last stop bit completes
module sat_value_uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit AUTO_SEND    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        send,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic          byte_idx;
    logic          pending;
    logic [15:0]   last_value;
    logic [15:0]   shreg;
    logic          request;
    logic          bit_end;
    logic          start_frame;
    logic [7:0]    cur_byte;

    assign request     = send | (AUTO_SEND && (value != last_value));
    assign bit_end     = (baud_cnt == BAUD_LAST);
    assign start_frame = (state == S_IDLE) && (request || pending);
    assign cur_byte    = byte_idx ? shreg[7:0] : shreg[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            last_value <= 16'h0000;
            baud_cnt   <= '0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 1'b0;
            done       <= 1'b0;
        end else begin
            last_value <= value;
            done       <= 1'b0;

            // Any request during a frame, including the final stop-bit
            // cycle, is remembered as a single retransmission.
            if (request && (state != S_IDLE))
                pending <= 1'b1;

            if (state != S_IDLE)
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_frame) begin
                        state    <= S_START;
                        pending  <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        byte_idx <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_STOP;
                    end
                end
                default: begin
                    if (bit_end) begin
                        // The low byte follows the high byte's stop bit
                        // directly, with no idle gap.
                        if (!byte_idx) begin
                            byte_idx <= 1'b1;
                            state    <= S_START;
                        end else begin
                            byte_idx <= 1'b0;
                            state    <= S_IDLE;
                            done     <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Payload is snapshotted only at frame start, so it needs no reset.
    always_ff @(posedge clk) begin
        if (start_frame)
            shreg <= value;
    end

    // The line is decoded straight from state so that reset forces it high
    // without waiting for a clock edge.
    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sat_value_uart_tx.sv
module tb_sat_value_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_a = 16'h0000;
    logic [15:0] value_b = 16'h0000;
    logic        send_a = 1'b0;
    logic        send_b = 1'b0;
    logic        tx_a, busy_a, done_a;
    logic        tx_b, busy_b, done_b;
    logic        sel = 1'b0;
    logic        mon_tx, mon_busy, mon_done;
    logic        mon_active = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int frames_seen = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    sat_value_uart_tx #(.CLKS_PER_BIT(CPB), .AUTO_SEND(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .value(value_a), .send(send_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    sat_value_uart_tx #(.CLKS_PER_BIT(CPB), .AUTO_SEND(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .value(value_b), .send(send_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    assign mon_tx   = sel ? tx_b   : tx_a;
    assign mon_busy = sel ? busy_b : busy_a;
    assign mon_done = sel ? done_b : done_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!mon_active && exp_q.size() == 0 && !mon_busy) break;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Receiver: samples the selected line mid-bit, checks framing, busy and
    // the done pulse, and compares the decoded frame with the scoreboard.
    always begin
        logic [19:0] bits;
        logic        busy_ok;
        logic        aborted;
        logic [15:0] exp_v;
        @(negedge clk);
        if (rst_n && mon_tx == 1'b0) begin
            mon_active = 1'b1;
            bits = '0;
            busy_ok = 1'b1;
            aborted = 1'b0;
            for (int c = 0; c < 20 * CPB; c++) begin
                if (c > 0) @(negedge clk);
                if (!rst_n) begin
                    aborted = 1'b1;
                    break;
                end
                if (!mon_busy || mon_done) busy_ok = 1'b0;
                if (c % CPB == CPB / 2) bits[c / CPB] = mon_tx;
            end
            if (aborted) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                wait (rst_n);
            end else begin
                @(negedge clk);
                check("frame_done_pulse", 32'(mon_done), 32'd1);
                check("frame_busy_after", 32'(mon_busy), 32'd0);
                check("frame_tx_after", 32'(mon_tx), 32'd1);
                check("frame_busy_cont", 32'(busy_ok), 32'd1);
                check("frame_start_stop", 32'({bits[19], bits[10], bits[9], bits[0]}), 32'b1010);
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 32'({bits[8:1], bits[18:11]}), 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("frame_data", 32'({bits[8:1], bits[18:11]}), 32'(exp_v));
                end
                frames_seen++;
            end
            mon_active = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int f0;
        int n;
        bit seen;

        // Reset state
        value_a = 16'h12A5;
        step(2);
        check("rst_tx_a", 32'(tx_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_tx_b", 32'(tx_b), 32'd1);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;

        // Single frame: send in cycle 10, busy 80 cycles, done afterwards
        sel = 1'b0;
        f0 = frames_seen;
        step(10);
        send_a = 1'b1;
        exp_q.push_back(16'h12A5);
        step(1);
        send_a = 1'b0;
        @(negedge clk);
        check("single_first_tx", 32'(tx_a), 32'd0);
        check("single_first_busy", 32'(busy_a), 32'd1);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy_a) break;
            n++;
        end
        check("single_busy_len", 32'(n), 32'd80);
        check("single_done", 32'(done_a), 32'd1);
        @(negedge clk);
        check("single_done_once", 32'(done_a), 32'd0);
        wait_idle("single");
        step(30);
        check("single_frames", 32'(frames_seen - f0), 32'd1);

        // Auto-send on value change
        sel = 1'b1;
        step(2);
        f0 = frames_seen;
        value_b = 16'hFFFF;
        exp_q.push_back(16'hFFFF);
        wait_idle("auto");
        step(100);
        check("auto_frames", 32'(frames_seen - f0), 32'd1);
        check("auto_stable_idle", 32'(busy_b), 32'd0);

        // Coalescing: three requests during a frame, newest value wins
        sel = 1'b0;
        step(2);
        f0 = frames_seen;
        value_a = 16'h0001;
        send_a = 1'b1;
        exp_q.push_back(16'h0001);
        step(1);
        send_a = 1'b0;
        step(10);
        value_a = 16'h0002;
        send_a = 1'b1;
        step(1);
        send_a = 1'b0;
        step(10);
        value_a = 16'h0003;
        send_a = 1'b1;
        step(1);
        send_a = 1'b0;
        step(10);
        send_a = 1'b1;
        exp_q.push_back(16'h0003);
        step(1);
        send_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) begin
                seen = 1'b1;
                break;
            end
        end
        check("coal_done_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("coal_restart_busy", 32'(busy_a), 32'd1);
        check("coal_restart_tx", 32'(tx_a), 32'd0);
        wait_idle("coal");
        step(100);
        check("coal_frames", 32'(frames_seen - f0), 32'd2);

        // Request in the final stop-bit cycle is kept as pending
        f0 = frames_seen;
        value_a = 16'h5A3C;
        send_a = 1'b1;
        exp_q.push_back(16'h5A3C);
        step(1);
        send_a = 1'b0;
        step(79);
        @(negedge clk);
        check("bound_last_busy", 32'(busy_a), 32'd1);
        check("bound_last_done", 32'(done_a), 32'd0);
        send_a = 1'b1;
        exp_q.push_back(16'h5A3C);
        step(1);
        send_a = 1'b0;
        wait_idle("bound");
        step(50);
        check("bound_frames", 32'(frames_seen - f0), 32'd2);

        // Reset during bit 5 of the low byte
        f0 = frames_seen;
        value_a = 16'hBEEF;
        value_b = 16'hBEEF;
        send_a = 1'b1;
        exp_q.push_back(16'hBEEF);
        step(1);
        send_a = 1'b0;
        step(65);
        check("rstmid_pre_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx_a), 32'd1);
        check("rstmid_busy", 32'(busy_a), 32'd0);
        step(6);
        rst_n = 1'b1;
        step(150);
        check("rstmid_frames", 32'(frames_seen - f0), 32'd0);
        check("rstmid_idle", 32'(busy_a), 32'd0);
        check("rstmid_queue", 32'(exp_q.size()), 32'd0);

        // Saturation extremes
        f0 = frames_seen;
        value_a = 16'h0000;
        send_a = 1'b1;
        exp_q.push_back(16'h0000);
        step(1);
        send_a = 1'b0;
        wait_idle("ext_lo");
        value_a = 16'hFFFF;
        send_a = 1'b1;
        exp_q.push_back(16'hFFFF);
        step(1);
        send_a = 1'b0;
        wait_idle("ext_hi");
        step(20);
        check("ext_frames", 32'(frames_seen - f0), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
